// File: rtl/booth_pair_divider16bit_pkg.sv
// Shared constants, state encoding and magnitude helpers for the sequential
// signed 32/16 restoring divider.
package booth_pair_divider16bit_pkg;

   localparam int WIDTH      = 16;
   localparam int DWIDTH     = 2 * WIDTH;
   localparam int ITER_COUNT = 16;
   localparam int CNT_W      = 5;

   localparam logic [WIDTH-1:0] OVF_QUOTIENT = 16'h8000;
   localparam logic [CNT_W-1:0] ITER_INIT    = CNT_W'(ITER_COUNT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Two's-complement magnitude; the most negative value maps onto 2^(n-1),
   // which still fits the unsigned result width.
   function automatic logic [DWIDTH-1:0] mag_dividend(input logic [DWIDTH-1:0] v);
      return v[DWIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [WIDTH-1:0] mag_divisor(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/booth_pair_divider16bit_if.sv
// Request/result bundle for the divider: the issuer drives the master side,
// the divider sits on the slave side.
interface booth_pair_divider16bit_if;
   import booth_pair_divider16bit_pkg::*;

   logic              start;
   logic [DWIDTH-1:0] dividend;
   logic [WIDTH-1:0]  divisor;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  quotient;
   logic [WIDTH-1:0]  remainder;
   logic              dbz;
   logic              ovf;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, dbz, ovf
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, dbz, ovf
   );

endinterface

// File: rtl/booth_pair_divider16bit_div_step16bit.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor magnitude when it fits.
module div_step16bit
   import booth_pair_divider16bit_pkg::*;
(
   input  logic [WIDTH:0]   r_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] dvs_mag,
   output logic [WIDTH:0]   r_out,
   output logic             q_bit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH:0]   diff;

   always_comb begin
      shifted = {r_in, bit_in};
      q_bit   = (shifted >= {2'b00, dvs_mag});
      diff    = shifted[WIDTH:0] - {1'b0, dvs_mag};
      r_out   = q_bit ? diff : shifted[WIDTH:0];
   end

endmodule

// File: rtl/booth_pair_divider16bit.sv
// Sequential signed divider: 32-bit dividend / 16-bit divisor, one quotient bit
// per clock on magnitudes, then sign fixup. Fixed 17-cycle start-to-done latency.
module booth_pair_divider16bit
   import booth_pair_divider16bit_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset,
   booth_pair_divider16bit_if.slave       bus
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sign_quo_q, sign_quo_d;
   logic              sign_rem_q, sign_rem_d;
   logic              pre_dbz_q, pre_dbz_d;
   logic              pre_ovf_q, pre_ovf_d;
   logic [WIDTH:0]    rem_q, rem_d;
   logic [WIDTH-1:0]  dlo_q, dlo_d;
   logic [WIDTH-1:0]  dvs_mag_q, dvs_mag_d;
   logic [WIDTH-1:0]  raw_lo_q, raw_lo_d;
   logic [WIDTH-1:0]  quotient_q, quotient_d;
   logic [WIDTH-1:0]  remainder_q, remainder_d;
   logic              dbz_q, dbz_d;
   logic              ovf_q, ovf_d;

   logic [DWIDTH-1:0] in_dvd_mag;
   logic [WIDTH-1:0]  in_dvs_mag;
   logic [WIDTH:0]    step_r;
   logic              step_q;
   logic [WIDTH-1:0]  qmag;
   logic [WIDTH-1:0]  rmag;
   logic              q_range_ovf;

   div_step16bit u_step (
      .r_in    (rem_q),
      .bit_in  (dlo_q[WIDTH-1]),
      .dvs_mag (dvs_mag_q),
      .r_out   (step_r),
      .q_bit   (step_q)
   );

   always_comb begin
      in_dvd_mag = mag_dividend(bus.dividend);
      in_dvs_mag = mag_divisor(bus.divisor);
      // Quotient bits are shifted into dlo as dividend bits are shifted out.
      qmag        = dlo_q;
      rmag        = rem_q[WIDTH-1:0];
      q_range_ovf = sign_quo_q ? (qmag > 16'h8000) : (qmag > 16'h7FFF);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      sign_quo_d  = sign_quo_q;
      sign_rem_d  = sign_rem_q;
      pre_dbz_d   = pre_dbz_q;
      pre_ovf_d   = pre_ovf_q;
      rem_d       = rem_q;
      dlo_d       = dlo_q;
      dvs_mag_d   = dvs_mag_q;
      raw_lo_d    = raw_lo_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               sign_quo_d = bus.dividend[DWIDTH-1] ^ bus.divisor[WIDTH-1];
               sign_rem_d = bus.dividend[DWIDTH-1];
               rem_d      = {1'b0, in_dvd_mag[DWIDTH-1:WIDTH]};
               dlo_d      = in_dvd_mag[WIDTH-1:0];
               dvs_mag_d  = in_dvs_mag;
               raw_lo_d   = bus.dividend[WIDTH-1:0];
               pre_dbz_d  = (bus.divisor == '0);
               // High half already >= divisor means the quotient needs > 16 bits.
               pre_ovf_d  = (in_dvd_mag[DWIDTH-1:WIDTH] >= in_dvs_mag);
               cnt_d      = ITER_INIT;
               busy_d     = 1'b1;
               state_d    = ST_ITER;
            end
         end

         ST_ITER: begin
            rem_d = step_r;
            dlo_d = {dlo_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_FIX;
            end
         end

         ST_FIX: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (pre_dbz_q) begin
               dbz_d       = 1'b1;
               ovf_d       = 1'b0;
               quotient_d  = '0;
               remainder_d = raw_lo_q;
            end else if (pre_ovf_q || q_range_ovf) begin
               dbz_d       = 1'b0;
               ovf_d       = 1'b1;
               quotient_d  = OVF_QUOTIENT;
               remainder_d = '0;
            end else begin
               dbz_d       = 1'b0;
               ovf_d       = 1'b0;
               quotient_d  = sign_quo_q ? (~qmag + 1'b1) : qmag;
               remainder_d = sign_rem_q ? (~rmag + 1'b1) : rmag;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sign_quo_q  <= 1'b0;
         sign_rem_q  <= 1'b0;
         pre_dbz_q   <= 1'b0;
         pre_ovf_q   <= 1'b0;
         rem_q       <= '0;
         dlo_q       <= '0;
         dvs_mag_q   <= '0;
         raw_lo_q    <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sign_quo_q  <= sign_quo_d;
         sign_rem_q  <= sign_rem_d;
         pre_dbz_q   <= pre_dbz_d;
         pre_ovf_q   <= pre_ovf_d;
         rem_q       <= rem_d;
         dlo_q       <= dlo_d;
         dvs_mag_q   <= dvs_mag_d;
         raw_lo_q    <= raw_lo_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.dbz       = dbz_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_booth_pair_divider16bit.sv
// Directed and random checks of the signed divider against an integer-arithmetic
// reference model; one line printed per division.
module tb_booth_pair_divider16bit;
   import booth_pair_divider16bit_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   booth_pair_divider16bit_if bus ();

   booth_pair_divider16bit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: signed integer division truncates toward zero and the
   // remainder follows the dividend; anything outside 16-bit signed range is ovf.
   function automatic void model(input logic [31:0] dvd, input logic [15:0] dvs,
                                 output logic [15:0] q, output logic [15:0] r,
                                 output logic dz, output logic ov);
      longint a, b, qq, rr;
      a = longint'($signed(dvd));
      b = longint'($signed(dvs));
      dz = 1'b0;
      ov = 1'b0;
      if (b == 0) begin
         dz = 1'b1;
         q  = 16'h0000;
         r  = dvd[15:0];
      end else begin
         qq = a / b;
         rr = a % b;
         if (qq > 32767 || qq < -32768) begin
            ov = 1'b1;
            q  = 16'h8000;
            r  = 16'h0000;
         end else begin
            q = qq[15:0];
            r = rr[15:0];
         end
      end
   endfunction

   // Called one step after a clock edge; the start pulse is sampled at the next edge.
   task automatic run_op(input logic [31:0] dvd, input logic [15:0] dvs,
                         input bit hold, input int inject_cyc, input string tag);
      logic [15:0] eq, er;
      logic        ed, eo;
      int          lat, busy_cnt;
      model(dvd, dvs, eq, er, ed, eo);
      bus.start    = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dvs;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = 16'($urandom);
      busy_cnt     = bus.busy ? 1 : 0;
      lat          = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c == inject_cyc) begin
            bus.start    = 1'b1;
            bus.dividend = 32'h0000_0064;
            bus.divisor  = 16'h0001;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (bus.done) begin
            lat = c;
            break;
         end
         if (bus.busy) busy_cnt++;
      end
      $display("[TB] %s dvd=%h dvs=%h -> q=%h r=%h dbz=%b ovf=%b latency=%0d",
               tag, dvd, dvs, bus.quotient, bus.remainder, bus.dbz, bus.ovf, lat);
      chk({tag, "_latency"}, 32'(lat), 32'd17);
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd17);
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      chk({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
      chk({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
      chk({tag, "_dbz"}, 32'(bus.dbz), 32'(ed));
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
      if (hold) begin
         @(posedge clk); #1;
         chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
         chk({tag, "_q_held"}, 32'(bus.quotient), 32'(eq));
         chk({tag, "_r_held"}, 32'(bus.remainder), 32'(er));
      end
   endtask

   initial begin
      logic [31:0] d, rnd;
      logic [15:0] v;
      int          pulses;

      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_quotient", 32'(bus.quotient), 32'd0);
      chk("rst_remainder", 32'(bus.remainder), 32'd0);
      chk("rst_dbz", 32'(bus.dbz), 32'd0);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);

      run_op(32'd100,        16'd7,      1'b1, 0, "pos_pos");
      run_op(32'hFFFF_FF9C,  16'd7,      1'b1, 0, "neg_pos");
      run_op(32'd100,        16'hFFF9,   1'b1, 0, "pos_neg");
      run_op(32'hFFFF_FF9C,  16'hFFF9,   1'b1, 0, "neg_neg");
      run_op(32'h0000_1234,  16'h0000,   1'b1, 0, "div_by_zero");
      run_op(32'h7FFF_0000,  16'd2,      1'b1, 0, "ovf_high");
      run_op(32'h8000_0000,  16'hFFFF,   1'b1, 0, "ovf_min_m1");
      run_op(32'hFFFF_8000,  16'd1,      1'b1, 0, "min_quotient");
      run_op(32'h0000_8000,  16'd1,      1'b1, 0, "ovf_pos_32768");
      run_op(32'h8000_0000,  16'h8000,   1'b1, 0, "ovf_min_min");
      run_op(32'hC000_0001,  16'h8000,   1'b1, 0, "big_neg_div");
      run_op(32'd1000,       16'd10,     1'b1, 5, "start_while_busy");

      run_op(32'd1000,       16'd10,     1'b0, 0, "b2b_first");
      run_op(32'd77,         16'hFFFB,   1'b1, 0, "b2b_second");

      for (int i = 0; i < 40; i++) begin
         rnd = $urandom;
         v   = 16'($urandom);
         if ($urandom_range(0, 9) == 0) v = 16'h0000;
         case ($urandom_range(0, 3))
            0:       d = {{12{rnd[19]}}, rnd[19:0]};
            1:       d = {{16{rnd[15]}}, rnd[15:0]};
            2:       d = {{8{rnd[23]}}, rnd[23:0]};
            default: d = rnd;
         endcase
         run_op(d, v, (i % 2) == 0, 0, $sformatf("rand%0d", i));
      end

      run_op(32'd1000, 16'd10, 1'b1, 0, "pre_abort");
      bus.start    = 1'b1;
      bus.dividend = 32'd5000;
      bus.divisor  = 16'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_quotient", 32'(bus.quotient), 32'd0);
      chk("abort_remainder", 32'(bus.remainder), 32'd0);
      chk("abort_dbz", 32'(bus.dbz), 32'd0);
      chk("abort_ovf", 32'(bus.ovf), 32'd0);
      pulses = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.done) pulses++;
      end
      $display("[TB] abort: reset mid-operation, done pulses afterwards=%0d", pulses);
      chk("abort_no_done", 32'(pulses), 32'd0);

      run_op(32'd77, 16'hFFFB, 1'b1, 0, "after_abort");

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_pair_divider16bit.md
Name: booth_pair_divider16bit

Overview:
- Sequential signed divider, the inverse of the team's 16x16 fast multiplier: 32-bit dividend / 16-bit divisor -> 16-bit quotient + 16-bit remainder.
- Restoring division on magnitudes, one quotient bit per clock, then sign fixup.
- Sits beside the fastmultiplier in the arithmetic unit.
- start/busy/done handshake; fixed latency regardless of operands.

Parameters:
WIDTH, 16, divisor/quotient/remainder width; dividend is 2*WIDTH. Only 16 is verified.

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-high
start  in  1  request; sampled only in IDLE
dividend  in  2*WIDTH  signed dividend, sampled with start
divisor  in  WIDTH  signed divisor, sampled with start
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse: results valid
quotient  out  WIDTH  signed quotient, held until next done
remainder  out  WIDTH  signed remainder, held until next done
dbz  out  1  divide-by-zero flag, held with results
ovf  out  1  quotient-overflow flag, held with results

Behaviour:
- Reset: state IDLE; busy, done, dbz, ovf = 0; quotient, remainder = 0; internal registers and counter cleared. Reset wins over every other input, including mid-operation; the aborted operation never produces done.
- States: IDLE -> ITER -> FIX -> IDLE.
- IDLE, start=1 at edge k:
  - Latch sign_q = dividend[31]^divisor[15] and sign_r = dividend[31].
  - Latch 32-bit unsigned |dividend| and 16-bit unsigned |divisor|. |-2^31| = 2^31 and |-32768| = 32768 fit these widths.
  - Latch pre_dbz = (divisor==0) and pre_ovf = (|dividend|[31:16] >= |divisor|).
  - Counter = 16, busy = 1, state = ITER.
- ITER, edges k+1..k+16, one restoring step each:
  - Partial remainder R is 17 bits, initialised to {0,|dividend|[31:16]}.
  - Shift {R, low dividend bits} left by 1; trial = R - {0,|divisor|}.
  - If trial >= 0: R = trial, q bit = 1. Otherwise R is kept, q bit = 0.
  - Counter decrements. At edge k+16 (counter reaches 0) state = FIX.
- FIX, edge k+17: outputs registered, done = 1, busy = 0, state = IDLE.
  - Normal: quotient = sign_q ? -qmag : qmag; remainder = sign_r ? -rmag : rmag. Truncation toward zero; remainder takes the dividend's sign.
  - ovf additionally set if qmag > 32767 with sign_q = 0, or qmag > 32768 with sign_q = 1.
  - Precedence: pre_dbz > pre_ovf/ovf > normal.
  - dbz: dbz = 1, ovf = 0, quotient = 0, remainder = dividend[15:0].
  - ovf: ovf = 1, quotient = 16'h8000, remainder = 0.
- Latency: done is high during the cycle after edge k+17, i.e. exactly 17 clocks after start is sampled, for every operand, dbz and ovf included.
- done is high for exactly one cycle. quotient, remainder, dbz and ovf hold until the next FIX edge or reset.
- start while busy is ignored, with no effect on the operation in progress.
- start in the cycle done is high (state is IDLE) is accepted: back-to-back issue with period 17.
- dividend and divisor are don't-care except at the start sampling edge.

Decomposition:
- Shared package holds:
  - WIDTH
  - state encoding (IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2)
  - iteration count constant (16)
  - ovf quotient constant 16'h8000
- One sub-module: div_step16bit. Combinational single restoring step: inputs R (17 bits), next dividend bit, |divisor|; outputs new R and q bit. ITER instantiates it once. The top level holds the FSM, counter, magnitude/negate logic and output registers.

Test Plan:
1. dividend = 100, divisor = 7, start for 1 cycle -> done exactly 17 cycles later, quotient = 14, remainder = 2, dbz = ovf = 0, busy high for 17 cycles.
2. -100/7 -> quotient = 16'hFFF2, remainder = 16'hFFFE. 100/-7 -> quotient = 16'hFFF2, remainder = 2. -100/-7 -> quotient = 14, remainder = 16'hFFFE.
3. 32'h00001234 / 0 -> dbz = 1, ovf = 0, quotient = 0, remainder = 16'h1234, done still at 17 cycles.
4. Overflow and boundary:
   - 32'h7FFF0000/2 -> ovf = 1, quotient = 16'h8000, remainder = 0.
   - 32'h80000000/-1 -> ovf = 1.
   - 32'hFFFF8000/1 -> quotient = 16'h8000, ovf = 0.
   - 32'h00008000/1 -> ovf = 1.
5. start at cycle 5 of an operation -> ignored, first result unchanged. reset at cycle 8 -> busy = 0 and all outputs 0 next cycle, no done pulse.
6. Back-to-back: 1000/10, then start with 77/-5 in the done cycle -> results 100/0, then exactly 17 cycles later 16'hFFF1/2.
